// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
//   state_t : sequencer FSM states
//   MAXN    : largest supported square dimension
//   IW      : width of the i/j/k index counters
//   WSH     : element index -> byte offset shift (32-bit words)
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    WR_C,
    DONE
  } state_t;

  localparam int MAXN = 8;

  // Index counter width for a given maximum dimension (never below 1 bit).
  function automatic int idx_w(input int maxn);
    return (maxn > 1) ? $clog2(maxn) : 1;
  endfunction

  localparam int IW  = idx_w(MAXN);
  localparam int WSH = 2;

endpackage

// File: rtl/mm_mac.sv
// Registered multiply-accumulate.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator (wins over en)
//   en         : acc <= acc + op_a*op_b
//   op_a, op_b : operands
//   acc        : running sum, low DW bits only (wraps silently)
module mm_mac
  import mm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [DW-1:0] acc
);

  // Truncating the product to DW bits makes signed and unsigned results equal.
  always_ff @(posedge clk) begin
    if (reset || clr) acc <= '0;
    else if (en)      acc <= acc + op_a * op_b;
  end

endmodule

// File: rtl/mm_seq.sv
// Matrix-multiply sequencer: C = A x B on square row-major matrices through a
// single-port word memory with a req/ack handshake.
//   clk, reset          : clock, synchronous active-high reset
//   start, dim          : launch pulse and dimension N (1..MAXN legal)
//   a_base/b_base/c_base: byte base addresses of A, B, C
//   mem_req/we/addr/wdata, mem_rdata/ack : memory port; a transfer completes
//                         at the posedge where req and ack are both high
//   busy, done, err     : status back to control
module mm_seq
  import mm_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int MAXN = mm_pkg::MAXN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   dim,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] c_base,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int          CW  = idx_w(MAXN);
  localparam logic [CW:0] ONE = (CW+1)'(1);

  state_t          state;
  logic [CW:0]     n_r;
  logic [CW-1:0]   i, j, k;
  logic [CW-1:0]   i_nx, j_nx;
  logic [AW-1:0]   a_r, b_r, c_r;
  logic [DW-1:0]   op_a, op_b, acc;
  logic            dim_ok, k_last, j_last, i_last;
  logic            mac_clr, mac_en;

  // Byte address of element (r,c) of an n x n row-major matrix at base.
  // Everything is modulo 2^AW, so a base near the top simply wraps.
  function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                              input logic [CW:0]   r,
                                              input logic [CW:0]   c,
                                              input logic [CW:0]   n);
    logic [AW-1:0] idx;
    idx = AW'(r) * AW'(n) + AW'(c);
    return base + (idx << WSH);
  endfunction

  assign dim_ok = (dim != 32'd0) && (dim <= 32'(MAXN));
  assign k_last = ({1'b0, k} == n_r - ONE);
  assign j_last = ({1'b0, j} == n_r - ONE);
  assign i_last = ({1'b0, i} == n_r - ONE);

  // Row-major walk over C: j fastest, i on j wrap.
  always_comb begin
    j_nx = j_last ? '0 : j + CW'(1);
    i_nx = j_last ? i + CW'(1) : i;
  end

  // The accumulator restarts both on launch and once a C element is written.
  assign mac_clr = ((state == IDLE) && start && dim_ok) ||
                   ((state == WR_C) && mem_ack);
  assign mac_en  = (state == MAC);

  mm_mac #(.DW(DW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .op_a  (op_a),
    .op_b  (op_b),
    .acc   (acc)
  );

  // acc only moves in MAC, so it is stable for the whole of WR_C.
  assign mem_wdata = acc;

  // Outputs are registered alongside the state: each transition loads the
  // request/address the destination state needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      n_r      <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      a_r      <= '0;
      b_r      <= '0;
      c_r      <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dim_ok) begin
              n_r      <= dim[CW:0];
              a_r      <= a_base;
              b_r      <= b_base;
              c_r      <= c_base;
              i        <= '0;
              j        <= '0;
              k        <= '0;
              state    <= RD_A;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= a_base;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (mem_ack) begin
            op_a     <= mem_rdata;
            state    <= RD_B;
            mem_addr <= elem_addr(b_r, {1'b0, k}, {1'b0, j}, n_r);
          end
        end
        RD_B: begin
          if (mem_ack) begin
            op_b    <= mem_rdata;
            state   <= MAC;
            mem_req <= 1'b0;
          end
        end
        MAC: begin
          mem_req <= 1'b1;
          if (!k_last) begin
            k        <= k + CW'(1);
            state    <= RD_A;
            mem_addr <= elem_addr(a_r, {1'b0, i}, {1'b0, k} + ONE, n_r);
          end else begin
            state    <= WR_C;
            mem_we   <= 1'b1;
            mem_addr <= elem_addr(c_r, {1'b0, i}, {1'b0, j}, n_r);
          end
        end
        WR_C: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            k      <= '0;
            i      <= i_nx;
            j      <= j_nx;
            if (i_last && j_last) begin
              state   <= DONE;
              mem_req <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state    <= RD_A;
              mem_addr <= elem_addr(a_r, {1'b0, i_nx}, '0, n_r);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_seq.sv
module tb_mm_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dim, a_base, b_base, c_base;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, done, err;

  always #5 clk = ~clk;

  mm_seq #(.DW(32), .AW(32), .MAXN(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dim       (dim),
    .a_base    (a_base),
    .b_base    (b_base),
    .c_base    (c_base),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt, wr_cnt, max_delay, edges;
  bit          req_seen, done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
    mem[addr[11:2]] = data;
  endtask

  // Memory responder: decides ack on the falling edge, so a transfer it acks
  // completes at the following rising edge.
  task automatic responder();
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    int          wait_cnt;
    bit          fresh;
    txn_t        t;
    fresh = 1; wait_cnt = 0; h_addr = 0; h_wdata = 0; h_we = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && reset === 1'b0) begin
        req_seen = 1;
        if (fresh) begin
          h_addr = mem_addr; h_wdata = mem_wdata; h_we = mem_we;
          wait_cnt = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
          fresh = 0;
        end else begin
          chk("addr_stable", mem_addr, h_addr);
          chk("we_stable", {31'b0, mem_we}, {31'b0, h_we});
          chk("wdata_stable", mem_wdata, h_wdata);
        end
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_txn: observed addr 0x%0h expected none", mem_addr);
          end
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            chk("txn_we", {31'b0, mem_we}, {31'b0, t.we});
            chk("txn_addr", mem_addr, t.addr);
            if (t.we) chk("txn_wdata", mem_wdata, t.data);
          end
          if (mem_we) begin
            mem[mem_addr[11:2]] = mem_wdata;
            wr_cnt++;
          end else begin
            mem_rdata = mem[mem_addr[11:2]];
            rd_cnt++;
          end
          fresh = 1;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          wait_cnt--;
        end
      end else begin
        mem_ack = 1'b0;
        fresh   = 1;
      end
    end
  endtask

  // Reference model: queue the expected transfer sequence, then raise start.
  task automatic launch(input int n, input logic [31:0] ab, input logic [31:0] bb,
                        input logic [31:0] cb);
    logic [31:0] acc, av, bv, aa, ba, ca;
    txn_t        t;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++) begin
          aa = ab + 32'((i * n + k) * 4);
          ba = bb + 32'((k * n + j) * 4);
          av = mem[aa[11:2]];
          bv = mem[ba[11:2]];
          t.we = 0; t.addr = aa; t.data = 0; exp_q.push_back(t);
          t.we = 0; t.addr = ba; t.data = 0; exp_q.push_back(t);
          acc = acc + av * bv;
        end
        ca = cb + 32'((i * n + j) * 4);
        t.we = 1; t.addr = ca; t.data = acc; exp_q.push_back(t);
      end
    dim = 32'(n); a_base = ab; b_base = bb; c_base = cb;
    start = 1'b1;
  endtask

  // Edge 0 is the edge that samples start; returns the edge after which done
  // was seen. Optionally re-pulses start while the operation is running.
  task automatic wait_done(input int limit, input int pulse_at, output int e);
    e = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && e < limit) begin
      start = (e == pulse_at);
      @(posedge clk); e++; #1;
    end
    start = 1'b0;
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic post_done();
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_c_2x2(input string tag);
    logic [31:0] want [4];
    want = '{32'd19, 32'd22, 32'd43, 32'd50};
    for (int e = 0; e < 4; e++) chk(tag, mem[10'h0C0 + 10'(e)], want[e]);
  endtask

  task automatic clear_c();
    for (int e = 0; e < 4; e++) wr_word(32'h300 + 32'(e * 4), 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dim = 0; a_base = 0; b_base = 0; c_base = 0;
    mem_ack = 1'b0; mem_rdata = 0; max_delay = 0; rd_cnt = 0; wr_cnt = 0;
    req_seen = 0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    fork
      responder();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: 2x2, ack tied high
    wr_word(32'h100, 1); wr_word(32'h104, 2); wr_word(32'h108, 3); wr_word(32'h10C, 4);
    wr_word(32'h200, 5); wr_word(32'h204, 6); wr_word(32'h208, 7); wr_word(32'h20C, 8);
    rd_cnt = 0; wr_cnt = 0;
    launch(2, 32'h100, 32'h200, 32'h300);
    wait_done(200, -1, edges);
    chk("s1_done_edge", edges, 32'd28);
    post_done();
    check_c_2x2("s1_c");
    chk("s1_reads", rd_cnt, 32'd16);
    chk("s1_writes", wr_cnt, 32'd4);
    chk("s1_sb_empty", exp_q.size(), 32'd0);

    // 2: 1x1 with product wrapping past 32 bits
    wr_word(32'h040, 32'h0001_0000); wr_word(32'h080, 32'h0001_0001);
    launch(1, 32'h040, 32'h080, 32'h0C0);
    wait_done(50, -1, edges);
    chk("s2_done_edge", edges, 32'd4);
    post_done();
    chk("s2_c", mem[10'h030], 32'h0001_0000);

    // 3: illegal dimensions
    req_seen = 0; rd_cnt = 0; wr_cnt = 0;
    dim = 0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("s3_err_dim0", {31'b0, err}, 32'd1);
    chk("s3_busy_dim0", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("s3_err_pulse0", {31'b0, err}, 32'd0);
    dim = 9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("s3_err_dim9", {31'b0, err}, 32'd1);
    @(posedge clk); #1;
    chk("s3_err_pulse9", {31'b0, err}, 32'd0);
    chk("s3_busy_dim9", {31'b0, busy}, 32'd0);
    chk("s3_no_req", {31'b0, req_seen}, 32'd0);
    chk("s3_no_txn", rd_cnt + wr_cnt, 32'd0);

    // 4: random ack delays 0..5
    clear_c(); rd_cnt = 0; wr_cnt = 0; max_delay = 5;
    launch(2, 32'h100, 32'h200, 32'h300);
    wait_done(2000, -1, edges);
    post_done();
    check_c_2x2("s4_c");
    chk("s4_reads", rd_cnt, 32'd16);
    chk("s4_writes", wr_cnt, 32'd4);
    chk("s4_sb_empty", exp_q.size(), 32'd0);
    max_delay = 0;

    // 5: start pulsed while busy is ignored
    clear_c(); rd_cnt = 0; wr_cnt = 0;
    launch(2, 32'h100, 32'h200, 32'h300);
    wait_done(200, 5, edges);
    chk("s5_done_edge", edges, 32'd28);
    post_done();
    check_c_2x2("s5_c");
    chk("s5_writes", wr_cnt, 32'd4);
    chk("s5_sb_empty", exp_q.size(), 32'd0);

    // 6: reset during RD_B of element (1,0), then a clean rerun
    clear_c();
    launch(2, 32'h100, 32'h200, 32'h300);
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("s6_rdb_req", {31'b0, mem_req}, 32'd1);
    chk("s6_rdb_addr", mem_addr, 32'h200);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("s6_req_dropped", {31'b0, mem_req}, 32'd0);
    chk("s6_busy_dropped", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1;
    end
    chk("s6_no_done", {31'b0, done_seen}, 32'd0);
    exp_q.delete();
    clear_c(); rd_cnt = 0; wr_cnt = 0;
    launch(2, 32'h100, 32'h200, 32'h300);
    wait_done(200, -1, edges);
    chk("s6_done_edge", edges, 32'd28);
    post_done();
    check_c_2x2("s6_c");
    chk("s6_writes", wr_cnt, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
